// File: rtl/mpsoc_dbg_pkg.sv
// Shared definitions for the MPSoC debug JTAG TAP.
// Holds the instruction register width, the instruction codes and the
// 16-state TAP controller state type (4-bit encoded).
package mpsoc_dbg_pkg;

  localparam int JTAG_IR_WIDTH = 4;

  localparam logic [JTAG_IR_WIDTH-1:0] IR_EXTEST         = 4'b0000;
  localparam logic [JTAG_IR_WIDTH-1:0] IR_SAMPLE_PRELOAD = 4'b0001;
  localparam logic [JTAG_IR_WIDTH-1:0] IR_IDCODE         = 4'b0010;
  localparam logic [JTAG_IR_WIDTH-1:0] IR_DEBUG          = 4'b1000;
  localparam logic [JTAG_IR_WIDTH-1:0] IR_MBIST          = 4'b1001;
  localparam logic [JTAG_IR_WIDTH-1:0] IR_BYPASS         = 4'b1111;

  typedef enum logic [3:0] {
    S_TLR    = 4'h0,
    S_RTI    = 4'h1,
    S_SEL_DR = 4'h2,
    S_CAP_DR = 4'h3,
    S_SH_DR  = 4'h4,
    S_EX1_DR = 4'h5,
    S_PAU_DR = 4'h6,
    S_EX2_DR = 4'h7,
    S_UPD_DR = 4'h8,
    S_SEL_IR = 4'h9,
    S_CAP_IR = 4'hA,
    S_SH_IR  = 4'hB,
    S_EX1_IR = 4'hC,
    S_PAU_IR = 4'hD,
    S_EX2_IR = 4'hE,
    S_UPD_IR = 4'hF
  } tap_state_t;

endpackage

// File: rtl/mpsoc_dbg_jtag_tap_if.sv
// Connection between the TAP controller and the debug top level.
// Carries the TAP-state strobes, the latched-instruction selects, the
// serial returns from the scan chains and the raw TAP state for debug.
// There is no valid/ready handshake here: strobes and selects are levels
// that are meaningful on every TCK posedge.
//   master : the TAP (drives strobes/selects, reads chain returns)
//   slave  : the debug top level (reads strobes/selects, drives returns)
interface mpsoc_dbg_jtag_tap_if;
  import mpsoc_dbg_pkg::*;

  logic       tlr_o;
  logic       run_test_idle_o;
  logic       capture_dr_o;
  logic       shift_dr_o;
  logic       pause_dr_o;
  logic       update_dr_o;
  logic       debug_select_o;
  logic       extest_select_o;
  logic       sample_preload_select_o;
  logic       mbist_select_o;
  logic       debug_tdo_i;
  logic       bs_chain_tdo_i;
  logic       mbist_tdo_i;
  tap_state_t tap_state;

  modport master (
    output tlr_o, run_test_idle_o, capture_dr_o, shift_dr_o, pause_dr_o,
           update_dr_o, debug_select_o, extest_select_o,
           sample_preload_select_o, mbist_select_o, tap_state,
    input  debug_tdo_i, bs_chain_tdo_i, mbist_tdo_i
  );

  modport slave (
    input  tlr_o, run_test_idle_o, capture_dr_o, shift_dr_o, pause_dr_o,
           update_dr_o, debug_select_o, extest_select_o,
           sample_preload_select_o, mbist_select_o, tap_state,
    output debug_tdo_i, bs_chain_tdo_i, mbist_tdo_i
  );

endinterface

// File: rtl/mpsoc_dbg_tap_fsm.sv
// IEEE 1149.1 TAP state machine.
// Ports:
//   tck_i, trst_i : JTAG clock, asynchronous active-high reset
//   tms_i         : test mode select, sampled on posedge tck_i
//   state         : current TAP state (also exported for debug)
//   tlr .. upd_ir : one-hot decodes of the state register
module mpsoc_dbg_tap_fsm
  import mpsoc_dbg_pkg::*;
(
  input  logic       tck_i,
  input  logic       trst_i,
  input  logic       tms_i,
  output tap_state_t state,
  output logic       tlr,
  output logic       rti,
  output logic       cap_dr,
  output logic       sh_dr,
  output logic       pau_dr,
  output logic       upd_dr,
  output logic       cap_ir,
  output logic       sh_ir,
  output logic       upd_ir
);

  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      state <= S_TLR;
    end else begin
      case (state)
        S_TLR:    state <= tms_i ? S_TLR    : S_RTI;
        S_RTI:    state <= tms_i ? S_SEL_DR : S_RTI;
        S_SEL_DR: state <= tms_i ? S_SEL_IR : S_CAP_DR;
        S_CAP_DR: state <= tms_i ? S_EX1_DR : S_SH_DR;
        S_SH_DR:  state <= tms_i ? S_EX1_DR : S_SH_DR;
        S_EX1_DR: state <= tms_i ? S_UPD_DR : S_PAU_DR;
        S_PAU_DR: state <= tms_i ? S_EX2_DR : S_PAU_DR;
        S_EX2_DR: state <= tms_i ? S_UPD_DR : S_SH_DR;
        S_UPD_DR: state <= tms_i ? S_SEL_DR : S_RTI;
        S_SEL_IR: state <= tms_i ? S_TLR    : S_CAP_IR;
        S_CAP_IR: state <= tms_i ? S_EX1_IR : S_SH_IR;
        S_SH_IR:  state <= tms_i ? S_EX1_IR : S_SH_IR;
        S_EX1_IR: state <= tms_i ? S_UPD_IR : S_PAU_IR;
        S_PAU_IR: state <= tms_i ? S_EX2_IR : S_PAU_IR;
        S_EX2_IR: state <= tms_i ? S_UPD_IR : S_SH_IR;
        S_UPD_IR: state <= tms_i ? S_SEL_DR : S_RTI;
        default:  state <= S_TLR;
      endcase
    end
  end

  assign tlr    = (state == S_TLR);
  assign rti    = (state == S_RTI);
  assign cap_dr = (state == S_CAP_DR);
  assign sh_dr  = (state == S_SH_DR);
  assign pau_dr = (state == S_PAU_DR);
  assign upd_dr = (state == S_UPD_DR);
  assign cap_ir = (state == S_CAP_IR);
  assign sh_ir  = (state == S_SH_IR);
  assign upd_ir = (state == S_UPD_IR);

endmodule

// File: rtl/mpsoc_dbg_jtag_tap.sv
// JTAG TAP controller for the MPSoC debug interface.
// Holds the instruction register (shift + latched), the IDCODE and BYPASS
// data registers and the negedge-registered TDO mux.
// Ports:
//   tck_i, trst_i  : JTAG clock, asynchronous active-high reset
//   tms_i, tdi_i   : test mode select, serial data in
//   tdo_o, tdo_oe_o: serial data out and its enable, updated on negedge
//   dbg            : strobes/selects to the debug top level, chain returns
module mpsoc_dbg_jtag_tap
  import mpsoc_dbg_pkg::*;
#(
  parameter logic [31:0] IDCODE_VALUE = 32'h149511C3
) (
  input  logic                 tck_i,
  input  logic                 trst_i,
  input  logic                 tms_i,
  input  logic                 tdi_i,
  output logic                 tdo_o,
  output logic                 tdo_oe_o,
  mpsoc_dbg_jtag_tap_if.master dbg
);

  localparam logic [JTAG_IR_WIDTH-1:0] IR_CAPTURE = 4'b0101;

  tap_state_t               state;
  logic                     tlr, rti, cap_dr, sh_dr, pau_dr, upd_dr;
  logic                     cap_ir, sh_ir, upd_ir;
  logic [JTAG_IR_WIDTH-1:0] ir_shift;
  logic [JTAG_IR_WIDTH-1:0] ir_latched;
  logic [31:0]              idcode_reg;
  logic                     bypass_reg;
  logic                     tdo_next;

  mpsoc_dbg_tap_fsm u_fsm (
    .tck_i  (tck_i),
    .trst_i (trst_i),
    .tms_i  (tms_i),
    .state  (state),
    .tlr    (tlr),
    .rti    (rti),
    .cap_dr (cap_dr),
    .sh_dr  (sh_dr),
    .pau_dr (pau_dr),
    .upd_dr (upd_dr),
    .cap_ir (cap_ir),
    .sh_ir  (sh_ir),
    .upd_ir (upd_ir)
  );

  // Instruction register. The latched copy is what the selects decode, so
  // a new instruction only becomes visible on the posedge leaving UpdIR.
  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      ir_shift   <= IR_CAPTURE;
      ir_latched <= IR_IDCODE;
    end else begin
      if (cap_ir) begin
        ir_shift <= IR_CAPTURE;
      end else if (sh_ir) begin
        ir_shift <= {tdi_i, ir_shift[JTAG_IR_WIDTH-1:1]};
      end
      if (tlr) begin
        ir_latched <= IR_IDCODE;
      end else if (upd_ir) begin
        ir_latched <= ir_shift;
      end
    end
  end

  // Data registers. Pause states fall through with no enable asserted.
  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      idcode_reg <= IDCODE_VALUE;
      bypass_reg <= 1'b0;
    end else begin
      if (cap_dr && (ir_latched == IR_IDCODE)) begin
        idcode_reg <= IDCODE_VALUE;
      end else if (sh_dr && (ir_latched == IR_IDCODE)) begin
        idcode_reg <= {tdi_i, idcode_reg[31:1]};
      end
      if (cap_dr) begin
        bypass_reg <= 1'b0;
      end else if (sh_dr) begin
        bypass_reg <= tdi_i;
      end
    end
  end

  // Unrecognised instruction codes fall into the default arm and behave
  // as BYPASS.
  always_comb begin
    tdo_next = 1'b0;
    if (sh_ir) begin
      tdo_next = ir_shift[0];
    end else if (sh_dr) begin
      case (ir_latched)
        IR_IDCODE:                    tdo_next = idcode_reg[0];
        IR_DEBUG:                     tdo_next = dbg.debug_tdo_i;
        IR_EXTEST, IR_SAMPLE_PRELOAD: tdo_next = dbg.bs_chain_tdo_i;
        IR_MBIST:                     tdo_next = dbg.mbist_tdo_i;
        default:                      tdo_next = bypass_reg;
      endcase
    end
  end

  // Negedge launch gives the host a full half period of setup before it
  // samples TDO on the next posedge.
  always_ff @(negedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      tdo_o    <= 1'b0;
      tdo_oe_o <= 1'b0;
    end else begin
      tdo_o    <= tdo_next;
      tdo_oe_o <= sh_ir | sh_dr;
    end
  end

  assign dbg.tlr_o                   = tlr;
  assign dbg.run_test_idle_o         = rti;
  assign dbg.capture_dr_o            = cap_dr;
  assign dbg.shift_dr_o              = sh_dr;
  assign dbg.pause_dr_o              = pau_dr;
  assign dbg.update_dr_o             = upd_dr;
  assign dbg.debug_select_o          = (ir_latched == IR_DEBUG);
  assign dbg.extest_select_o         = (ir_latched == IR_EXTEST);
  assign dbg.sample_preload_select_o = (ir_latched == IR_SAMPLE_PRELOAD);
  assign dbg.mbist_select_o          = (ir_latched == IR_MBIST);
  assign dbg.tap_state               = state;

endmodule

// File: tb/tb_mpsoc_dbg_jtag_tap.sv
// Testbench for mpsoc_dbg_jtag_tap: table-driven instruction/TDO-mux vectors
// plus hand-written TAP sequences for reset, IDCODE, Capture-IR, DEBUG
// timing, BYPASS delay, state decodes and return to TLR.
module tb_mpsoc_dbg_jtag_tap;
  import mpsoc_dbg_pkg::*;

  localparam logic [31:0] EXP_IDCODE = 32'h149511C3;

  logic tck;
  logic trst;
  logic tms;
  logic tdi;
  logic tdo;
  logic tdo_oe;

  int n_checks;
  int n_errors;

  mpsoc_dbg_jtag_tap_if dbg_if ();

  mpsoc_dbg_jtag_tap dut (
    .tck_i    (tck),
    .trst_i   (trst),
    .tms_i    (tms),
    .tdi_i    (tdi),
    .tdo_o    (tdo),
    .tdo_oe_o (tdo_oe),
    .dbg      (dbg_if.master)
  );

  // ---------------- clock / reset ----------------
  initial tck = 1'b0;
  always #5 tck = ~tck;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  // Apply TMS/TDI, clock one posedge, return 1 time unit after the negedge
  // so negedge-registered outputs are settled when sampled.
  task automatic cyc(input logic t_ms, input logic t_di);
    tms = t_ms;
    tdi = t_di;
    @(posedge tck);
    @(negedge tck);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // From RTI: shift code into IR, stop in UpdIR.
  task automatic load_ir_upd(input logic [3:0] code);
    cyc(1'b1, 1'b0);  // SelDR
    cyc(1'b1, 1'b0);  // SelIR
    cyc(1'b0, 1'b0);  // CapIR
    cyc(1'b0, 1'b0);  // ShIR
    for (int i = 0; i < 4; i++) cyc(i == 3, code[i]);  // last -> Ex1IR
    cyc(1'b1, 1'b0);  // UpdIR
  endtask

  task automatic load_ir(input logic [3:0] code);
    load_ir_upd(code);
    cyc(1'b0, 1'b0);  // RTI, latched IR updates here
  endtask

  task automatic enter_shdr();
    cyc(1'b1, 1'b0);  // SelDR
    cyc(1'b0, 1'b0);  // CapDR
    cyc(1'b0, 1'b0);  // ShDR
  endtask

  task automatic exit_dr_from_ex1();
    cyc(1'b1, 1'b0);  // UpdDR
    cyc(1'b0, 1'b0);  // RTI
  endtask

  function automatic logic [3:0] sel_vec();
    return {dbg_if.debug_select_o, dbg_if.extest_select_o,
            dbg_if.sample_preload_select_o, dbg_if.mbist_select_o};
  endfunction

  // BYPASS-style data path: TDO is 0 first, then TDI delayed one clock.
  task automatic run_bypass(input logic [3:0] code);
    logic [7:0] data;
    logic       exp_bit;
    data = 8'hA5;
    load_ir(code);
    dbg_if.debug_tdo_i    = 1'b1;
    dbg_if.bs_chain_tdo_i = 1'b1;
    dbg_if.mbist_tdo_i    = 1'b1;
    enter_shdr();
    for (int i = 0; i < 9; i++) begin
      exp_bit = (i == 0) ? 1'b0 : data[i-1];
      check($sformatf("bypass_ir%0b_bit%0d", code, i), {31'd0, tdo}, {31'd0, exp_bit});
      cyc(i == 8, (i < 8) ? data[i] : 1'b0);
    end
    exit_dr_from_ex1();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] ir;
    logic       dbg_tdo;
    logic       bs_tdo;
    logic       mb_tdo;
    logic [3:0] exp_sel;  // {debug, extest, sample_preload, mbist}
    logic       exp_tdo;
  } vec_t;

  vec_t vecs[8];

  // ---------------- main test ----------------
  initial begin
    logic [31:0] word;
    logic [3:0]  cap_pat;

    n_checks = 0;
    n_errors = 0;
    trst = 1'b1;
    tms  = 1'b1;
    tdi  = 1'b0;
    dbg_if.debug_tdo_i    = 1'b0;
    dbg_if.bs_chain_tdo_i = 1'b0;
    dbg_if.mbist_tdo_i    = 1'b0;

    vecs[0] = '{IR_EXTEST,         1'b0, 1'b1, 1'b0, 4'b0100, 1'b1};
    vecs[1] = '{IR_SAMPLE_PRELOAD, 1'b1, 1'b0, 1'b1, 4'b0010, 1'b0};
    vecs[2] = '{IR_IDCODE,         1'b0, 1'b0, 1'b0, 4'b0000, 1'b1};
    vecs[3] = '{IR_DEBUG,          1'b1, 1'b0, 1'b0, 4'b1000, 1'b1};
    vecs[4] = '{IR_DEBUG,          1'b0, 1'b1, 1'b1, 4'b1000, 1'b0};
    vecs[5] = '{IR_MBIST,          1'b0, 1'b0, 1'b1, 4'b0001, 1'b1};
    vecs[6] = '{IR_BYPASS,         1'b1, 1'b1, 1'b1, 4'b0000, 1'b0};
    vecs[7] = '{4'b0111,           1'b1, 1'b1, 1'b1, 4'b0000, 1'b0};

    // Reset values
    repeat (2) @(negedge tck);
    #1;
    check("rst_tlr", {31'd0, dbg_if.tlr_o}, 32'd1);
    check("rst_decodes", {26'd0, dbg_if.run_test_idle_o, dbg_if.capture_dr_o,
          dbg_if.shift_dr_o, dbg_if.pause_dr_o, dbg_if.update_dr_o, 1'b0}, 32'd0);
    check("rst_selects", {28'd0, sel_vec()}, 32'd0);
    check("rst_tdo", {30'd0, tdo, tdo_oe}, 32'd0);
    trst = 1'b0;

    // IDCODE readout: TMS 0,1,0,0 then 32 shift clocks
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    word = '0;
    for (int i = 0; i < 32; i++) begin
      word[i] = tdo;
      check($sformatf("idcode_oe_%0d", i), {31'd0, tdo_oe}, 32'd1);
      cyc(i == 31, 1'b0);
    end
    check("idcode_word", word, EXP_IDCODE);
    check("ex1dr_oe", {31'd0, tdo_oe}, 32'd0);
    exit_dr_from_ex1();

    // Capture-IR pattern 0101 shifts out LSB first; TDI=0 leaves IR=EXTEST
    cap_pat = 4'b0101;
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("capir_bit%0d", i), {31'd0, tdo}, {31'd0, cap_pat[i]});
      check($sformatf("capir_oe%0d", i), {31'd0, tdo_oe}, 32'd1);
      cyc(i == 3, 1'b0);
    end
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    check("capir_extest_sel", {28'd0, sel_vec()}, 32'b0100);

    // Table-driven instruction decode and DR TDO mux
    for (int v = 0; v < 8; v++) begin
      load_ir(vecs[v].ir);
      check($sformatf("vec%0d_sel", v), {28'd0, sel_vec()}, {28'd0, vecs[v].exp_sel});
      dbg_if.debug_tdo_i    = vecs[v].dbg_tdo;
      dbg_if.bs_chain_tdo_i = vecs[v].bs_tdo;
      dbg_if.mbist_tdo_i    = vecs[v].mb_tdo;
      enter_shdr();
      check($sformatf("vec%0d_tdo", v), {31'd0, tdo}, {31'd0, vecs[v].exp_tdo});
      check($sformatf("vec%0d_oe", v), {31'd0, tdo_oe}, 32'd1);
      cyc(1'b1, 1'b0);
      exit_dr_from_ex1();
    end

    // DEBUG select latency and TDO following debug_tdo_i
    load_ir(IR_BYPASS);
    load_ir_upd(IR_DEBUG);
    check("dbg_sel_in_updir", {31'd0, dbg_if.debug_select_o}, 32'd0);
    cyc(1'b0, 1'b0);
    check("dbg_sel_after_updir", {31'd0, dbg_if.debug_select_o}, 32'd1);
    dbg_if.debug_tdo_i = 1'b1;
    enter_shdr();
    check("dbg_tdo_1", {31'd0, tdo}, 32'd1);
    dbg_if.debug_tdo_i = 1'b0;
    cyc(1'b0, 1'b1);
    check("dbg_tdo_0", {31'd0, tdo}, 32'd0);
    dbg_if.debug_tdo_i = 1'b1;
    cyc(1'b0, 1'b0);
    check("dbg_tdo_1b", {31'd0, tdo}, 32'd1);
    cyc(1'b1, 1'b0);
    exit_dr_from_ex1();

    // BYPASS delay, defined and undefined codes
    run_bypass(IR_BYPASS);
    run_bypass(4'b0111);

    // DR state decode walk including pause
    check("walk_rti", {31'd0, dbg_if.run_test_idle_o}, 32'd1);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    check("walk_capdr", {31'd0, dbg_if.capture_dr_o}, 32'd1);
    cyc(1'b0, 1'b0);
    check("walk_shdr", {31'd0, dbg_if.shift_dr_o}, 32'd1);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    check("walk_pausedr", {31'd0, dbg_if.pause_dr_o}, 32'd1);
    check("walk_pause_oe", {31'd0, tdo_oe}, 32'd0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    check("walk_upddr", {31'd0, dbg_if.update_dr_o}, 32'd1);
    cyc(1'b0, 1'b0);

    // From ShIR, five TMS=1 reach TLR; the exit shift still lands (IR=1000)
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b1);  // Ex1IR
    cyc(1'b1, 1'b0);  // UpdIR
    cyc(1'b1, 1'b0);  // SelDR
    check("tlr_path_dbg_sel", {31'd0, dbg_if.debug_select_o}, 32'd1);
    cyc(1'b1, 1'b0);  // SelIR
    cyc(1'b1, 1'b0);  // TLR
    check("tlr_reached", {31'd0, dbg_if.tlr_o}, 32'd1);
    cyc(1'b0, 1'b0);  // RTI, IR forced to IDCODE by the TLR posedge
    check("tlr_ir_idcode_sel", {28'd0, sel_vec()}, 32'd0);
    enter_shdr();
    check("tlr_ir_idcode_tdo", {31'd0, tdo}, 32'd1);
    cyc(1'b1, 1'b0);
    exit_dr_from_ex1();

    // Asynchronous reset in the middle of a DEBUG shift
    load_ir(IR_DEBUG);
    dbg_if.debug_tdo_i = 1'b1;
    enter_shdr();
    cyc(1'b0, 1'b1);
    check("pre_rst_oe", {31'd0, tdo_oe}, 32'd1);
    trst = 1'b1;
    #1;
    check("mid_rst_tlr", {31'd0, dbg_if.tlr_o}, 32'd1);
    check("mid_rst_shdr", {31'd0, dbg_if.shift_dr_o}, 32'd0);
    check("mid_rst_oe_tdo", {30'd0, tdo, tdo_oe}, 32'd0);
    check("mid_rst_dbg_sel", {31'd0, dbg_if.debug_select_o}, 32'd0);
    tms = 1'b1;
    #1;
    trst = 1'b0;
    cyc(1'b1, 1'b0);
    check("post_rst_tlr", {31'd0, dbg_if.tlr_o}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
